// File: rtl/dmme_pkg.sv
// Shared types for the dmme systolic array: PE mode encodings, the column
// drain state machine states and the partial-sum word width.
package dmme_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        MODE_DENDEN = 2'b00,
        MODE_SPADEN = 2'b01,
        MODE_PASS   = 2'b11
    } pe_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRAIN = 2'b01,
        DONE  = 2'b10
    } drain_state_t;

endpackage

// File: rtl/dmme_sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty flags derived from an
// occupancy counter; DEPTH must be a power of two so pointers wrap naturally.
module dmme_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Storage array; cleared on reset so the show-ahead output reads zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pe_col_drain.sv
// Drains one systolic-array column: shifts the PE partial sums out through the
// bottom PE, tags each with its row and a last flag, and streams them out.
module pe_col_drain #(
    parameter int ROWS   = 4,
    parameter int DATA_W = dmme_pkg::DATA_W,
    parameter int DEPTH  = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [DATA_W-1:0]        col_cin,
    output logic                     col_en,
    output logic [1:0]               col_mode,
    output logic [DATA_W-1:0]        res_data,
    output logic [$clog2(ROWS)-1:0]  res_row,
    output logic                     res_last,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     busy,
    output logic                     done
);

    import dmme_pkg::*;

    localparam int ROW_W = $clog2(ROWS);
    localparam int FW    = DATA_W + ROW_W + 1;

    drain_state_t      state_r;
    pe_mode_t          mode_r;
    logic [ROW_W-1:0]  row_cnt_r;
    logic              busy_r;
    logic              done_r;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              last_s;
    logic              col_en_s;
    logic              pop_s;
    logic [FW-1:0]     push_word_s;
    logic [FW-1:0]     head_word_s;

    // The FIFO count is the only throttle: a full FIFO freezes the column even
    // if a pop frees a slot on the same edge.
    assign col_en_s    = (state_r == DRAIN) && !fifo_full_s;
    assign last_s      = (row_cnt_r == ROW_W'(ROWS - 1));
    assign push_word_s = {col_cin, row_cnt_r, last_s};
    assign pop_s       = !fifo_empty_s && res_ready;

    assign col_en    = col_en_s;
    assign col_mode  = mode_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign res_valid = !fifo_empty_s;
    assign {res_data, res_row, res_last} = head_word_s;

    // Drain sequencer with registered mode/busy/done decodes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            row_cnt_r <= {ROW_W{1'b0}};
            mode_r    <= MODE_DENDEN;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r   <= DRAIN;
                        row_cnt_r <= {ROW_W{1'b0}};
                        mode_r    <= MODE_PASS;
                        busy_r    <= 1'b1;
                    end else begin
                        mode_r <= MODE_DENDEN;
                        busy_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (col_en_s) begin
                        if (last_s) begin
                            state_r   <= DONE;
                            row_cnt_r <= {ROW_W{1'b0}};
                            mode_r    <= MODE_DENDEN;
                            done_r    <= 1'b1;
                        end else begin
                            row_cnt_r <= row_cnt_r + ROW_W'(1);
                        end
                    end else begin
                        row_cnt_r <= row_cnt_r;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    mode_r  <= MODE_DENDEN;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    row_cnt_r <= {ROW_W{1'b0}};
                    mode_r    <= MODE_DENDEN;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    dmme_sync_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (col_en_s),
        .wdata   (push_word_s),
        .pop     (pop_s),
        .rdata   (head_word_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

endmodule

// File: tb/tb_pe_col_drain.sv
// Scoreboard bench for pe_col_drain: a DEPTH=8 and a DEPTH=2 instance, each
// fed by a 4-deep shift-register model of the PE column.
module tb_pe_col_drain;

    logic clock;
    logic reset_n;

    logic        start_a, col_en_a, res_last_a, res_valid_a, ready_a, busy_a, done_a;
    logic [1:0]  col_mode_a, res_row_a;
    logic [31:0] col_cin_a, res_data_a;
    logic        start_b, col_en_b, res_last_b, res_valid_b, ready_b, busy_b, done_b;
    logic [1:0]  col_mode_b, res_row_b;
    logic [31:0] col_cin_b, res_data_b;

    logic [31:0] col_a [4];
    logic [31:0] col_b [4];
    logic [31:0] ldv   [4];
    logic        ld_a, ld_b;

    logic [34:0] exp_a [$];
    logic [34:0] exp_b [$];
    int n_tests = 0;
    int n_fail  = 0;
    int max_cnt_b = 0;

    pe_col_drain #(.ROWS(4), .DATA_W(32), .DEPTH(8)) u_a (
        .clock(clock), .reset_n(reset_n), .start(start_a), .col_cin(col_cin_a),
        .col_en(col_en_a), .col_mode(col_mode_a), .res_data(res_data_a),
        .res_row(res_row_a), .res_last(res_last_a), .res_valid(res_valid_a),
        .res_ready(ready_a), .busy(busy_a), .done(done_a));

    pe_col_drain #(.ROWS(4), .DATA_W(32), .DEPTH(2)) u_b (
        .clock(clock), .reset_n(reset_n), .start(start_b), .col_cin(col_cin_b),
        .col_en(col_en_b), .col_mode(col_mode_b), .res_data(res_data_b),
        .res_row(res_row_b), .res_last(res_last_b), .res_valid(res_valid_b),
        .res_ready(ready_b), .busy(busy_b), .done(done_b));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Column models: load on request, otherwise shift toward the bottom on col_en.
    always @(posedge clock) begin
        if (ld_a) col_a <= ldv;
        else if (col_en_a) begin
            for (int i = 0; i < 3; i++) col_a[i] <= col_a[i+1];
            col_a[3] <= 32'h0;
        end
        if (ld_b) col_b <= ldv;
        else if (col_en_b) begin
            for (int i = 0; i < 3; i++) col_b[i] <= col_b[i+1];
            col_b[3] <= 32'h0;
        end
    end
    assign col_cin_a = col_a[0];
    assign col_cin_b = col_b[0];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic push_exp(input bit sel, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w [4];
        logic [34:0] e;
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            e = {w[i], 2'(i), 1'(i == 3)};
            if (sel) exp_b.push_back(e);
            else     exp_a.push_back(e);
        end
    endtask

    // Monitors: compare each accepted head word against the scoreboard.
    always @(negedge clock) begin
        logic [34:0] e;
        if (reset_n) begin
            if (res_valid_a && ready_a) begin
                if (exp_a.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL word_a: got unexpected %0h expected none", res_data_a);
                end else begin
                    e = exp_a.pop_front();
                    check("word_a", {29'h0, res_data_a, res_row_a, res_last_a}, {29'h0, e});
                end
            end
            if (res_valid_b && ready_b) begin
                if (exp_b.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL word_b: got unexpected %0h expected none", res_data_b);
                end else begin
                    e = exp_b.pop_front();
                    check("word_b", {29'h0, res_data_b, res_row_b, res_last_b}, {29'h0, e});
                end
            end
        end
        if (int'(u_b.u_fifo.count_r) > max_cnt_b) max_cnt_b = int'(u_b.u_fifo.count_r);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input bit sel, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
        ldv = '{w0, w1, w2, w3};
        if (sel) ld_b = 1'b1; else ld_a = 1'b1;
        tick();
        ld_a = 1'b0;
        ld_b = 1'b0;
    endtask

    task automatic wait_drained(input bit sel, input string nm);
        int k = 0;
        while (k < 200 && (sel ? (exp_b.size() != 0 || busy_b) : (exp_a.size() != 0 || busy_a))) begin
            tick();
            k++;
        end
        check(nm, sel ? exp_b.size() : exp_a.size(), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int en_n, done_n, done_cyc;
        reset_n = 1'b1;
        start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        ld_a = 1'b0; ld_b = 1'b0;
        ldv = '{32'h0, 32'h0, 32'h0, 32'h0};
        #1 reset_n = 1'b0;
        tick(); tick();
        check("rst_col_en", col_en_a, 0);
        check("rst_col_mode", col_mode_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_valid", {res_valid_a, res_valid_b}, 0);
        check("rst_res", {res_data_a, res_row_a, res_last_a}, 0);
        reset_n = 1'b1;
        tick();

        // Basic drain
        load(0, 32'h00009999, 32'h11110000, 32'h00001111, 32'h12345678);
        push_exp(0, 32'h00009999, 32'h11110000, 32'h00001111, 32'h12345678);
        start_a = 1'b1; tick(); start_a = 1'b0;
        en_n = 0; done_n = 0; done_cyc = -1;
        for (int c = 1; c <= 7; c++) begin
            if (col_en_a) en_n++;
            if (done_a) begin done_n++; if (done_cyc < 0) done_cyc = c; end
            if (c == 1) begin
                check("basic_busy_c1", busy_a, 1);
                check("basic_mode_c1", col_mode_a, 2'b11);
            end
            if (c == 6) check("basic_busy_c6", busy_a, 0);
            tick();
        end
        check("basic_en_cycles", en_n, 4);
        check("basic_done_cycle", done_cyc, 5);
        check("basic_done_pulses", done_n, 1);
        wait_drained(0, "basic_drained");

        // Ignored start
        load(0, 32'hA0A00001, 32'hA0A00002, 32'hA0A00003, 32'hA0A00004);
        push_exp(0, 32'hA0A00001, 32'hA0A00002, 32'hA0A00003, 32'hA0A00004);
        start_a = 1'b1; tick();
        en_n = 0;
        for (int c = 1; c <= 9; c++) begin
            start_a = (c == 2 || c == 5);
            if (col_en_a) en_n++;
            if (c == 6) check("ign_busy_c6", busy_a, 0);
            tick();
        end
        start_a = 1'b0;
        check("ign_en_cycles", en_n, 4);
        check("ign_busy_end", busy_a, 0);
        wait_drained(0, "ign_drained");

        // Reset mid-drain
        load(0, 32'hB0B00001, 32'hB0B00002, 32'hB0B00003, 32'hB0B00004);
        push_exp(0, 32'hB0B00001, 32'hB0B00002, 32'hB0B00003, 32'hB0B00004);
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick(); tick();
        reset_n = 1'b0;
        #1;
        check("mrst_col_en", col_en_a, 0);
        check("mrst_col_mode", col_mode_a, 0);
        check("mrst_valid", res_valid_a, 0);
        check("mrst_res", {res_data_a, res_row_a, res_last_a}, 0);
        check("mrst_flags", {busy_a, done_a}, 0);
        check("mrst_pending", exp_a.size(), 3);
        exp_a.delete();
        tick(); tick();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mrst_valid_after", {res_valid_a, busy_a}, 0);
        end
        load(0, 32'hC0C00001, 32'hC0C00002, 32'hC0C00003, 32'hC0C00004);
        push_exp(0, 32'hC0C00001, 32'hC0C00002, 32'hC0C00003, 32'hC0C00004);
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_drained(0, "mrst_drained");

        // Back-to-back drains with a consumer stalling every other cycle
        load(0, 32'hD0000001, 32'hD0000002, 32'hD0000003, 32'hD0000004);
        en_n = 0;
        for (int k = 0; k < 12; k++) begin
            start_a = (k == 0 || k == 6);
            ready_a = (k % 2 == 1);
            if (k == 0) push_exp(0, 32'hD0000001, 32'hD0000002, 32'hD0000003, 32'hD0000004);
            if (k == 5) begin
                ldv = '{32'hE0000001, 32'hE0000002, 32'hE0000003, 32'hE0000004};
                ld_a = 1'b1;
            end else ld_a = 1'b0;
            if (k == 6) push_exp(0, 32'hE0000001, 32'hE0000002, 32'hE0000003, 32'hE0000004);
            if (col_en_a) en_n++;
            tick();
        end
        start_a = 1'b0; ld_a = 1'b0;
        for (int k = 12; k < 60 && exp_a.size() != 0; k++) begin
            ready_a = (k % 2 == 1);
            tick();
        end
        check("b2b_en_cycles", en_n, 8);
        check("b2b_drained", exp_a.size(), 0);
        ready_a = 1'b1;

        // Backpressure on the DEPTH=2 instance
        ready_b = 1'b0;
        load(1, 32'hF0000001, 32'hF0000002, 32'hF0000003, 32'hF0000004);
        push_exp(1, 32'hF0000001, 32'hF0000002, 32'hF0000003, 32'hF0000004);
        start_b = 1'b1; tick(); start_b = 1'b0;
        en_n = 0;
        for (int c = 1; c <= 13; c++) begin
            ready_b = (c >= 10);
            if (col_en_b) en_n++;
            if (c == 2) check("bp_en_c2", col_en_b, 1);
            if (c == 5) begin
                check("bp_en_c5", col_en_b, 0);
                check("bp_hold_c5", col_cin_b, 32'hF0000003);
            end
            if (c == 11) check("bp_en_c11", col_en_b, 1);
            tick();
        end
        check("bp_en_cycles", en_n, 4);
        wait_drained(1, "bp_drained");

        // Pop while full on the DEPTH=2 instance
        ready_b = 1'b0;
        load(1, 32'h0F000001, 32'h0F000002, 32'h0F000003, 32'h0F000004);
        push_exp(1, 32'h0F000001, 32'h0F000002, 32'h0F000003, 32'h0F000004);
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            ready_b = (c == 4 || c >= 7);
            if (c == 4) check("pwf_en_popedge", col_en_b, 0);
            if (c == 5) begin
                check("pwf_en_after", col_en_b, 1);
                check("pwf_nocap", col_cin_b, 32'h0F000003);
            end
            if (c == 6) begin
                check("pwf_full_again", col_en_b, 0);
                check("pwf_cap", col_cin_b, 32'h0F000004);
            end
            tick();
        end
        ready_b = 1'b1;
        wait_drained(1, "pwf_drained");
        check("pwf_max_count", max_cnt_b, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_col_drain.md
# pe_col_drain

Result drain for one column of the dmme systolic array. After a compute pass, each PE in the column holds a 32-bit partial sum on `cOut`, chained to the next PE's `cin`. This block is the receiving end of that chain: it drives `en`/`mode` into the column so the sums shift out one per cycle, and captures them from the bottom PE. It buffers the words and hands them to the write-back path over a valid/ready stream, throttling the column when the buffer fills.

## Interface
- `ROWS`, 4: PEs per column, i.e. words per drain.
- `DATA_W`, 32: width of a `cOut` word.
- `DEPTH`, 8: FIFO entries; must be ≥ 2 and a power of two.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to drain the column; ignored while `busy`.
- `col_cin`  in  DATA_W  `cOut` of the bottom PE.
- `col_en`  out  1  `en` to every PE in the column.
- `col_mode`  out  2  `mode` to every PE in the column.
- `res_data`  out  DATA_W  head FIFO word.
- `res_row`  out  $clog2(ROWS)  source row of `res_data`; 0 is the bottom PE.
- `res_last`  out  1  `res_data` is the final word of a drain.
- `res_valid`  out  1  FIFO not empty.
- `res_ready`  in  1  consumer accepts the head word when `res_valid` is also high.
- `busy`  out  1  a drain is in progress.
- `done`  out  1  one-cycle pulse after the last capture.

## Operation
- **States.** `IDLE`, `DRAIN`, `DONE`.
  - `IDLE` → `DRAIN` on `start`. This loads `row_cnt = 0`.
  - `DRAIN` → `DONE` on the capture where `row_cnt == ROWS-1`.
  - `DONE` → `IDLE` unconditionally, after one cycle.
- **Column control.** `col_mode = MODE_PASS` (2'b11) while in `DRAIN`, and `MODE_DENDEN` (2'b00) otherwise.
- **Shift enable.** `col_en = (state == DRAIN) && !fifo_full`. This is combinational from state and FIFO count.
- **Capture.** At every rising edge where `col_en` is 1, push `{col_cin, row_cnt, row_cnt == ROWS-1}` and increment `row_cnt`. The value captured is the bottom PE's output before the shift.
- **Stall.** While the FIFO is full, `col_en` is 0 and the PEs hold their values. No word is lost or duplicated.
- **Full with pop.** Push is never attempted when full, even if a pop happens in the same cycle. The FIFO count is the sole throttle.
- **Pop.** Occurs on `res_valid && res_ready`. Output is show-ahead: the head word is visible while `res_valid` is high.
- **Simultaneous push and pop.** When not full, both happen in the same cycle and the count is unchanged.
- **Empty.** `res_valid` is 0; `res_data`, `res_row` and `res_last` hold their last values, and their content is don't-care.
- **Flags.** `busy = (state != IDLE)`. `done` is high only in `DONE`.
- **`start` handling.** `start` while `busy` is dropped with no effect. `start` in the `DONE` cycle is also dropped.
- **Back-to-back drains.** A new drain may begin before the FIFO empties. Words from consecutive drains are separated only by `res_last`.
- **Reset (asserted at any time, including mid-drain).**
  - State goes to `IDLE`, `row_cnt` to 0 and the FIFO is emptied.
  - All outputs go to 0: `col_en`, `col_mode`, `res_*`, `busy`, `done`.
  - PE contents are not restored; recovering them is the system's responsibility.

## Timing
- `start` sampled at edge 0 → `busy` and `col_en` high in cycle 1 → first word pushed at edge 1 → `res_valid` high in cycle 2.
- With no stall and `res_ready` held at 1: one word per cycle; `ROWS` captures on edges 1..ROWS; `done` high in cycle ROWS+1; `busy` low from cycle ROWS+2.
- Pop-to-room latency: a pop at edge k makes `col_en` high in cycle k+1 (full → not full).
- Minimum drain-to-drain spacing: ROWS+2 cycles.

## Structure
- **Package `dmme_pkg`** holds:
  - the `pe_mode_t` mode encodings: `MODE_DENDEN = 2'b00`, `MODE_SPADEN = 2'b01`, `MODE_PASS = 2'b11`;
  - the drain state enum;
  - `DATA_W`, shared with `pe`.
- **Sub-module `dmme_sync_fifo`**: parameterised width and depth, single clock, asynchronous active-low reset, show-ahead output, `full`/`empty` flags, count register of width $clog2(DEPTH)+1.
- **Top level**: the FSM, `row_cnt` and the packing of `{data, row, last}` into the FIFO word.

## Test plan
- **Basic drain.** Reset; model the column as a 4-deep shift register with bottom→top contents 32'h00009999, 32'h11110000, 32'h00001111, 32'h12345678; pulse `start`; hold `res_ready=1`.
  - Words out in that order with `res_row` 0, 1, 2, 3 and `res_last` only on 32'h12345678.
  - `done` in cycle 5; `col_en` high for exactly 4 cycles.
- **Backpressure.** `DEPTH=2`, `res_ready=0` until cycle 10, then 1.
  - `col_en` drops after 2 captures and the column model does not shift.
  - All 4 words arrive in order, none duplicated.
- **Ignored start.** Assert `start` again in cycles 2 and 5.
  - No second drain occurs; `busy` falls in cycle 6.
- **Reset mid-drain.** Assert `reset_n=0` in cycle 3 after 2 captures.
  - All outputs 0 in the same cycle and `res_valid` stays 0.
  - A fresh `start` after release drains 4 words with `res_row` starting at 0.
- **Back-to-back drains.** Two drains separated by 6 cycles with the consumer stalling every other cycle.
  - 8 words in order, `res_last` on the 4th and 8th.
- **Pop while full.** With `DEPTH=2`, the FIFO full and `res_ready=1`:
  - No capture on the pop edge; `col_en` high the next cycle; count never exceeds 2.
